i2s_rx: RTL

- Receive-side counterpart to the board's I2S clock/data generator. It samples external I2S lines (BCLK, WS, SD) in the single system clock domain and deserializes MSB-first stereo words.
- Each complete left/right pair is presented on a valid/ready output port for downstream logic (FIFO, LED/debug counters).
- Bus mode is standard (Philips) I2S: the MSB arrives one BCLK after the WS transition. BCLK is a data input only, never used as a clock.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_sync_edge.sv | 41 ++++
 rtl/i2s_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receiver.
//   - i2s_state_e : receiver framing state (hunt for alignment, waiting for left, waiting for pair)
//   - WS_LEFT / WS_RIGHT : word-select levels for each channel
//   - DEFAULT_DATA_W : default sample width per channel
package i2s_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam logic [1:0] HUNT      = 2'd0;
  localparam logic [1:0] LEFT_PEND = 2'd1;
  localparam logic [1:0] PAIR_PEND = 2'd2;

  typedef enum logic [1:0] {
    StHunt     = HUNT,
    StLeftPend = LEFT_PEND,
    StPairPend = PAIR_PEND
  } i2s_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// N-stage synchronizer for the asynchronous I2S lines plus a BCLK rise-event pulse.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   bclk_i/ws_i/sd_i  : raw I2S pins
//   ws_o/sd_o         : synchronized word select and serial data
//   rise_o            : one-clk pulse when synchronized BCLK goes 0 -> 1
module i2s_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic bclk_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic ws_o,
  output logic sd_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] bclk_q, ws_q, sd_q;
  logic                   bclk_hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_q      <= '0;
      ws_q        <= '0;
      sd_q        <= '0;
      bclk_hist_q <= 1'b0;
    end else begin
      bclk_q      <= {bclk_q[SYNC_STAGES-2:0], bclk_i};
      ws_q        <= {ws_q[SYNC_STAGES-2:0], ws_i};
      sd_q        <= {sd_q[SYNC_STAGES-2:0], sd_i};
      bclk_hist_q <= bclk_q[SYNC_STAGES-1];
    end
  end

  assign ws_o   = ws_q[SYNC_STAGES-1];
  assign sd_o   = sd_q[SYNC_STAGES-1];
  assign rise_o = bclk_q[SYNC_STAGES-1] & ~bclk_hist_q;

endmodule

// File: rtl/i2s_rx.sv
// Standard (Philips) I2S receiver: oversamples BCLK/WS/SD in the clk domain, deserializes
// MSB-first words and presents complete left/right pairs on a valid/ready port.
// Ports:
//   clk, reset                 : system clock, synchronous active-high reset
//   i2s_bclk, i2s_ws, i2s_sd   : I2S lines (BCLK is sampled as data, never used as a clock)
//   out_left, out_right        : presented sample pair
//   out_valid, out_ready       : pair handshake
//   short_word                 : sticky, a word carried fewer than DATA_W bits
//   overrun                    : sticky, a pair was dropped while the output was full
//   err_clr                    : clears both sticky flags (a same-cycle set wins)
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2s_bclk,
  input  logic              i2s_ws,
  input  logic              i2s_sd,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              short_word,
  output logic              overrun,
  input  logic              err_clr
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  logic bclk_rise, ws_s, sd_s;

  i2s_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .bclk_i(i2s_bclk),
    .ws_i  (i2s_ws),
    .sd_i  (i2s_sd),
    .ws_o  (ws_s),
    .sd_o  (sd_s),
    .rise_o(bclk_rise)
  );

  // Captured bit from the last rise event; processed the following cycle.
  logic samp_v_q, samp_ws_q, samp_sd_q;
  logic ws_d_q, ws_d_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_in, word;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_in;
  logic              boundary;

  i2s_state_e state_q, state_d;
  logic       store_left, pair_done, word_short;

  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic [DATA_W-1:0] out_left_q, out_left_d, out_right_q, out_right_d;
  logic              out_valid_q, out_valid_d;
  logic              short_q, short_d, overrun_q, overrun_d;
  logic              load, drop;

  // Deserializer: the boundary bit is the LSB of the outgoing word, so it is shifted in
  // before the word is finalized.
  always_comb begin
    boundary = samp_v_q && (samp_ws_q != ws_d_q);
    if (cnt_q < FULL_CNT) begin
      shift_in = {shift_q[DATA_W-2:0], samp_sd_q};
      cnt_in   = cnt_q + CNT_W'(1);
    end else begin
      shift_in = shift_q;
      cnt_in   = cnt_q;
    end
    // Short words are left-aligned with zero LSBs.
    word = (cnt_in < FULL_CNT) ? (shift_in << (FULL_CNT - cnt_in)) : shift_in;

    ws_d_d  = ws_d_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (samp_v_q) begin
      ws_d_d = samp_ws_q;
      if (boundary) begin
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = shift_in;
        cnt_d   = cnt_in;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHunt:     if (boundary && (samp_ws_q == WS_LEFT)) state_d = StLeftPend;
      StLeftPend: if (store_left) state_d = StPairPend;
      StPairPend: if (pair_done) state_d = StLeftPend;
      default:    state_d = StHunt;
    endcase
  end

  // FSM: outputs. The word finalized in hunt is a partial and is neither kept nor flagged.
  always_comb begin
    store_left = 1'b0;
    pair_done  = 1'b0;
    unique case (state_q)
      StLeftPend: store_left = boundary && (ws_d_q == WS_LEFT);
      StPairPend: pair_done  = boundary && (ws_d_q == WS_RIGHT);
      default:    ;
    endcase
    word_short = boundary && (state_q != StHunt) && (cnt_in < FULL_CNT);
  end

  // Output register and sticky flags
  always_comb begin
    load = pair_done && (!out_valid_q || out_ready);
    drop = pair_done && out_valid_q && !out_ready;

    left_hold_d = store_left ? word : left_hold_q;
    out_left_d  = load ? left_hold_q : out_left_q;
    out_right_d = load ? word : out_right_q;

    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    short_d   = word_short ? 1'b1 : (err_clr ? 1'b0 : short_q);
    overrun_d = drop       ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_v_q    <= 1'b0;
      samp_ws_q   <= 1'b0;
      samp_sd_q   <= 1'b0;
      ws_d_q      <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      left_hold_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      short_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      samp_v_q <= bclk_rise;
      if (bclk_rise) begin
        samp_ws_q <= ws_s;
        samp_sd_q <= sd_s;
      end
      ws_d_q      <= ws_d_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      left_hold_q <= left_hold_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      short_q     <= short_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_left   = out_left_q;
  assign out_right  = out_right_q;
  assign out_valid  = out_valid_q;
  assign short_word = short_q;
  assign overrun    = overrun_q;

endmodule
